rs_dec_ctrl: RTL and testbench
==============================

Name: rs_dec_ctrl

Overview:
- Sequences one codeword at a time through the rsdec Reed-Solomon decoder for the BER simulation datapath.
- Accepts a received-symbol stream with valid/ready, drives the decoder's enable/x/k inputs, and holds the received codeword in a local buffer.
- XORs each buffered symbol with the decoder's error output to emit corrected symbols.
- Keeps saturating statistics counters that the BER IP register bank reads.

Parameters:
- N_SYMS, 255, codeword length in symbols; also buffer depth.
- K_SYMS, 239, message length driven on dec_k; must satisfy (N_SYMS-K_SYMS) even and >=2.
- TIMEOUT, 1023, maximum cycles in WAIT before abort.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_sym  in  8  received symbol.
- in_valid  in  1  in_sym valid.
- in_ready  out  1  controller accepts in_sym this cycle.
- dec_x  out  8  symbol to decoder.
- dec_enable  out  1  decoder input enable.
- dec_k  out  8  constant K_SYMS.
- dec_error  in  8  decoder error magnitude for the current output symbol.
- dec_valid  in  1  decoder output-symbol valid.
- dec_with_error  in  1  decoder syndrome-nonzero flag.
- out_sym  out  8  corrected symbol.
- out_valid  out  1  out_sym valid; no backpressure.
- out_last  out  1  last symbol of codeword.
- cw_count  out  CNT_W  codewords completed.
- cw_err_count  out  CNT_W  codewords with nonzero syndrome.
- sym_corr_count  out  CNT_W  symbols with dec_error != 0.
- timeout_err  out  1  sticky: WAIT exceeded TIMEOUT.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst. All state updates occur on the rising edge of clk.
- Reset values:
  - State is IDLE.
  - in_ready, dec_enable, out_valid, out_last, busy and timeout_err are 0.
  - dec_x, out_sym and all counters are 0.
  - All internal counters are cleared.
  - A reset asserted mid-codeword abandons that codeword; no partial output is emitted afterwards.
- IDLE:
  - in_ready=1.
  - On in_valid, go to LOAD with the first symbol accepted in the same cycle (it counts as symbol 0).
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready handshake writes the symbol to buffer address wr_idx and registers dec_x=in_sym, dec_enable=1 for exactly one cycle. dec_x/dec_enable are 1-cycle latency from the handshake.
  - Gaps in in_valid produce dec_enable=0.
  - After handshake number N_SYMS (wr_idx==N_SYMS-1), go to WAIT; in_ready drops the next cycle.
- WAIT:
  - in_ready=0.
  - The timeout counter increments each cycle.
  - If dec_with_error is seen high on any cycle, set internal err_seen.
  - On the first dec_valid, go to DRAIN and process that symbol in the same cycle.
  - If the timeout counter reaches TIMEOUT: set timeout_err (sticky until rst), go to IDLE, no output, cw_count unchanged.
- DRAIN:
  - For each dec_valid cycle: out_sym = buf[rd_idx] ^ dec_error, out_valid=1, registered with 1-cycle latency; rd_idx then increments.
  - The buffer read is addressed one cycle ahead so that the output latency stays 1 cycle.
  - If dec_error!=0, sym_corr_count += 1.
  - dec_valid low cycles produce out_valid=0 and no index advance.
  - Symbol rd_idx==N_SYMS-1 asserts out_last with its out_valid. That cycle:
    - cw_count += 1.
    - cw_err_count += err_seen.
    - err_seen is cleared.
    - Go to IDLE.
  - dec_with_error is also sampled in DRAIN.
- Next codeword: IDLE may accept the next codeword's first symbol in the cycle after out_last. Exactly one codeword is in flight at any time.
- Counters:
  - All counters saturate at all-ones and never wrap.
  - Simultaneous increments of different counters are independent.
- Index ranges: wr_idx and rd_idx are 0..N_SYMS-1. Width is clog2(N_SYMS). Both clear on leaving LOAD/DRAIN respectively and on timeout.
- Outputs: dec_k is constant K_SYMS. busy=1 in LOAD, WAIT and DRAIN.

Decomposition:
- Shared package rs_ctrl_pkg:
  - SYM_W=8.
  - State enum {IDLE, LOAD, WAIT, DRAIN}.
  - Default N_SYMS, K_SYMS and TIMEOUT constants, reused by the BER top and the bench.
- One sub-module: rs_sym_buf, a simple dual-port RAM.
  - Depth N_SYMS, width 8.
  - One write port, one registered read port.
  - Infers BRAM or LUTRAM.
- The controller FSM, the counters and the XOR stay in rs_dec_ctrl.

Test Plan:
- Clean codeword: feed 255 valid encoded symbols back-to-back; model returns dec_error=0 and with_error=0 → 255 outputs equal input, out_last on the 255th, cw_count=1, cw_err_count=0, sym_corr_count=0.
- Corrected errors: received symbols 10 and 200 corrupted by 0x5A; model drives dec_error=0x5A at those positions and with_error=1 → output equals the original codeword, sym_corr_count=2, cw_err_count=1.
- Gapped traffic: in_valid toggles every other cycle on input, and dec_valid has random gaps on output → dec_enable mirrors the handshakes with 1-cycle delay; output order and values are intact; in_ready=0 throughout WAIT and DRAIN.
- Timeout: complete LOAD, never assert dec_valid → after 1023 WAIT cycles timeout_err=1, state IDLE, cw_count unchanged, in_ready=1; timeout_err persists across the next good codeword.
- Mid-operation reset: assert rst at symbol 100 of DRAIN → next cycle out_valid=0, all counters 0, in_ready=1; a following clean codeword decodes correctly.
- Saturation: force-preload cw_count to 0xFFFFFFFF, run one codeword → remains 0xFFFFFFFF.

Source files
------------

// File: rtl/rs_ctrl_pkg.sv
// Shared types and default sizing for the Reed-Solomon decoder controller.
// The BER top and the bench both take their default codeword geometry from here.
package rs_ctrl_pkg;

   localparam int SYM_W       = 8;
   localparam int N_SYMS_DEF  = 255;
   localparam int K_SYMS_DEF  = 239;
   localparam int TIMEOUT_DEF = 1023;

   // Controller phases: accept a codeword, wait for the decoder, stream the
   // corrected codeword out.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } ctrl_state_e;

   // Apply the decoder's error magnitude to a received symbol.
   function automatic logic [SYM_W-1:0] fix_sym(input logic [SYM_W-1:0] rx_sym,
                                                input logic [SYM_W-1:0] err_mag);
      return rx_sym ^ err_mag;
   endfunction

endpackage

// File: rtl/rs_sym_buf.sv
// Received-codeword buffer: simple dual-port RAM, one write port and one
// registered read port, so it maps onto block or distributed RAM.
module rs_sym_buf
   import rs_ctrl_pkg::*;
#(
   parameter int DEPTH = N_SYMS_DEF,
   parameter int W     = SYM_W,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // Write on we; read data appears one cycle after the address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/rs_dec_ctrl.sv
// Sequences one codeword at a time through the rsdec decoder: buffers the
// received symbols while feeding the decoder, then XORs each buffered symbol
// with the decoder's error magnitude on the way out, and keeps saturating
// statistics for the BER register bank.
//
// Handshakes: a symbol moves on in_sym only in a cycle where in_valid and
// in_ready are both high; in_valid may toggle freely. The output side has no
// backpressure: out_sym is taken in every cycle out_valid is high, and the
// decoder side likewise presents one symbol per dec_enable / dec_valid cycle.
// The codeword length should satisfy (N_SYMS-K_SYMS) even and >= 2.
module rs_dec_ctrl
   import rs_ctrl_pkg::*;
#(
   parameter int N_SYMS  = N_SYMS_DEF,
   parameter int K_SYMS  = K_SYMS_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SYM_W-1:0] in_sym,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [SYM_W-1:0] dec_x,
   output logic             dec_enable,
   output logic [SYM_W-1:0] dec_k,
   input  logic [SYM_W-1:0] dec_error,
   input  logic             dec_valid,
   input  logic             dec_with_error,
   output logic [SYM_W-1:0] out_sym,
   output logic             out_valid,
   output logic             out_last,
   output logic [CNT_W-1:0] cw_count,
   output logic [CNT_W-1:0] cw_err_count,
   output logic [CNT_W-1:0] sym_corr_count,
   output logic             timeout_err,
   output logic             busy,
   output ctrl_state_e      state_dbg
);

   localparam int AW = (N_SYMS > 1) ? $clog2(N_SYMS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   ctrl_state_e      state;
   ctrl_state_e      state_nxt;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic [AW-1:0]    rd_idx_nxt;
   logic [TW-1:0]    to_cnt;
   logic             err_seen;
   logic             err_any;
   logic             accept;
   logic             consume;
   logic             last_wr;
   logic             last_rd;
   logic             timeout_hit;
   logic [SYM_W-1:0] buf_rdata;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign dec_k     = SYM_W'(K_SYMS);
   assign state_dbg = state;

   // Event decode and next-state / next-read-index selection.
   always_comb begin
      accept      = in_valid & in_ready;
      consume     = dec_valid & ((state == WAIT) | (state == DRAIN));
      last_wr     = accept & (wr_idx == AW'(N_SYMS - 1));
      last_rd     = consume & (rd_idx == AW'(N_SYMS - 1));
      timeout_hit = (state == WAIT) & ~dec_valid & (to_cnt == TW'(TIMEOUT - 1));
      err_any     = err_seen | dec_with_error;

      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = last_wr ? WAIT : LOAD;
            end
         end
         LOAD: begin
            if (last_wr) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // The first decoded symbol is already handled in this cycle.
            if (consume) begin
               state_nxt = last_rd ? IDLE : DRAIN;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (last_rd) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      rd_idx_nxt = rd_idx;
      if (last_rd || timeout_hit) begin
         rd_idx_nxt = '0;
      end else if (consume) begin
         rd_idx_nxt = rd_idx + AW'(1);
      end
   end

   // The buffer is read at the index the next output will use, so the
   // symbol is already waiting when dec_valid arrives.
   rs_sym_buf #(
      .DEPTH (N_SYMS),
      .W     (SYM_W),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_idx),
      .wdata (in_sym),
      .raddr (rd_idx_nxt),
      .rdata (buf_rdata)
   );

   // Controller state, registered outputs and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         in_ready       <= 1'b0;
         busy           <= 1'b0;
         dec_enable     <= 1'b0;
         dec_x          <= '0;
         wr_idx         <= '0;
         rd_idx         <= '0;
         to_cnt         <= '0;
         err_seen       <= 1'b0;
         timeout_err    <= 1'b0;
         out_valid      <= 1'b0;
         out_last       <= 1'b0;
         out_sym        <= '0;
         cw_count       <= '0;
         cw_err_count   <= '0;
         sym_corr_count <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt == IDLE) || (state_nxt == LOAD);
         busy     <= (state_nxt != IDLE);

         // Decoder input mirrors each accepted symbol one cycle later.
         dec_enable <= accept;
         if (accept) begin
            dec_x  <= in_sym;
            wr_idx <= last_wr ? '0 : wr_idx + AW'(1);
         end

         rd_idx <= rd_idx_nxt;

         if ((state == WAIT) && !consume && !timeout_hit) begin
            to_cnt <= to_cnt + TW'(1);
         end else begin
            to_cnt <= '0;
         end

         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end

         if (last_rd || timeout_hit) begin
            err_seen <= 1'b0;
         end else if (((state == WAIT) || (state == DRAIN)) && dec_with_error) begin
            err_seen <= 1'b1;
         end

         out_valid <= consume;
         out_last  <= last_rd;
         if (consume) begin
            out_sym <= fix_sym(buf_rdata, dec_error);
         end

         if (last_rd) begin
            cw_count <= sat_inc(cw_count);
         end
         if (last_rd && err_any) begin
            cw_err_count <= sat_inc(cw_err_count);
         end
         if (consume && (dec_error != '0)) begin
            sym_corr_count <= sat_inc(sym_corr_count);
         end
      end
   end

endmodule

// File: tb/tb_rs_dec_ctrl.sv
// Bench for rs_dec_ctrl: random codewords with known corruption, a mock
// decoder that reports the exact error magnitudes, and a per-instance output
// scoreboard. A second instance with 2-bit counters exercises saturation.
module tb_rs_dec_ctrl;
   import rs_ctrl_pkg::*;

   localparam int N  = N_SYMS_DEF;
   localparam int K  = K_SYMS_DEF;
   localparam int TO = TIMEOUT_DEF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_sym;
   logic       in_valid;
   logic [7:0] dec_error;
   logic       dec_valid;
   logic       dec_with_error;

   logic [1:0]       in_ready_w;
   logic [1:0][7:0]  dec_x_w;
   logic [1:0]       dec_enable_w;
   logic [1:0][7:0]  dec_k_w;
   logic [1:0][7:0]  out_sym_w;
   logic [1:0]       out_valid_w;
   logic [1:0]       out_last_w;
   logic [1:0][31:0] cw_w;
   logic [1:0][31:0] cwe_w;
   logic [1:0][31:0] scc_w;
   logic [1:0]       timeout_w;
   logic [1:0]       busy_w;
   logic [1:0][1:0]  state_w;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] orig [N];
   logic [7:0] rx   [N];
   longint     exp_cw   = 0;
   longint     exp_err  = 0;
   longint     exp_corr = 0;
   logic       exp_to   = 1'b0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected counter value for an instance: instance 1 has 2-bit counters.
   function automatic logic [31:0] sat_exp(input longint v, input int g);
      longint lim;
      lim = (g == 0) ? 64'hFFFF_FFFF : 64'd3;
      return (v > lim) ? lim[31:0] : v[31:0];
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int CW = (g == 0) ? 32 : 2;
      logic [CW-1:0] cwc;
      logic [CW-1:0] cwe;
      logic [CW-1:0] scc;
      logic [8:0]    exp_q[$];
      logic [8:0]    e;

      rs_dec_ctrl #(
         .N_SYMS  (N),
         .K_SYMS  (K),
         .TIMEOUT (TO),
         .CNT_W   (CW)
      ) dut (
         .clk            (clk),
         .rst            (rst),
         .in_sym         (in_sym),
         .in_valid       (in_valid),
         .in_ready       (in_ready_w[g]),
         .dec_x          (dec_x_w[g]),
         .dec_enable     (dec_enable_w[g]),
         .dec_k          (dec_k_w[g]),
         .dec_error      (dec_error),
         .dec_valid      (dec_valid),
         .dec_with_error (dec_with_error),
         .out_sym        (out_sym_w[g]),
         .out_valid      (out_valid_w[g]),
         .out_last       (out_last_w[g]),
         .cw_count       (cwc),
         .cw_err_count   (cwe),
         .sym_corr_count (scc),
         .timeout_err    (timeout_w[g]),
         .busy           (busy_w[g]),
         .state_dbg      (state_w[g])
      );

      assign cw_w[g]  = 32'(cwc);
      assign cwe_w[g] = 32'(cwe);
      assign scc_w[g] = 32'(scc);

      // Output scoreboard: every out_valid must match the next expected symbol.
      always @(negedge clk) begin
         if (out_valid_w[g]) begin
            if (exp_q.size() == 0) begin
               check_eq($sformatf("out_extra%0d", g), 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq($sformatf("out_sym%0d", g), 32'(out_sym_w[g]), 32'(e[7:0]));
               check_eq($sformatf("out_last%0d", g), 32'(out_last_w[g]), 32'(e[8]));
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [8:0] v);
      g_dut[0].exp_q.push_back(v);
      g_dut[1].exp_q.push_back(v);
   endtask

   task automatic flush_exp();
      g_dut[0].exp_q.delete();
      g_dut[1].exp_q.delete();
   endtask

   task automatic check_counts(input string tag);
      for (int g = 0; g < 2; g++) begin
         check_eq($sformatf("%s_cw%0d", tag, g), cw_w[g], sat_exp(exp_cw, g));
         check_eq($sformatf("%s_cwerr%0d", tag, g), cwe_w[g], sat_exp(exp_err, g));
         check_eq($sformatf("%s_symcorr%0d", tag, g), scc_w[g], sat_exp(exp_corr, g));
         check_eq($sformatf("%s_tmo%0d", tag, g), 32'(timeout_w[g]), 32'(exp_to));
      end
   endtask

   // mode 0: clean, 1: symbols 10 and 200 hit by 0x5A, 2: nerr random hits.
   task automatic gen_cw(input int mode, input int nerr, output int ncorr);
      int p;
      for (int i = 0; i < N; i++) begin
         orig[i] = 8'($urandom);
         rx[i]   = orig[i];
      end
      if (mode == 1) begin
         rx[10]  = orig[10] ^ 8'h5A;
         rx[200] = orig[200] ^ 8'h5A;
      end else if (mode == 2) begin
         for (int j = 0; j < nerr; j++) begin
            p     = int'($urandom_range(0, N - 1));
            rx[p] = orig[p] ^ 8'($urandom_range(1, 255));
         end
      end
      ncorr = 0;
      for (int i = 0; i < N; i++) begin
         if (rx[i] != orig[i]) ncorr++;
      end
   endtask

   // Push the received codeword in; every handshake must reappear on the
   // decoder port exactly one cycle later.
   task automatic feed_cw(input bit gapped);
      int         i;
      logic       v;
      logic       prev_v;
      logic [7:0] prev_sym;
      bit         tog;
      i        = 0;
      prev_v   = 1'b0;
      prev_sym = 8'h00;
      tog      = 1'b1;
      while (i < N) begin
         for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("dec_en%0d", g), 32'(dec_enable_w[g]), 32'(prev_v));
            if (prev_v) check_eq($sformatf("dec_x%0d", g), 32'(dec_x_w[g]), 32'(prev_sym));
            check_eq($sformatf("in_ready_load%0d", g), 32'(in_ready_w[g]), 32'd1);
         end
         v        = gapped ? tog : 1'b1;
         tog      = ~tog;
         in_valid = v;
         in_sym   = v ? rx[i] : 8'($urandom);
         prev_v   = v;
         prev_sym = rx[i];
         if (v) i++;
         step();
      end
      in_valid = 1'b0;
      for (int g = 0; g < 2; g++) begin
         check_eq($sformatf("dec_en_last%0d", g), 32'(dec_enable_w[g]), 32'd1);
         check_eq($sformatf("dec_x_last%0d", g), 32'(dec_x_w[g]), 32'(prev_sym));
         check_eq($sformatf("in_ready_wait%0d", g), 32'(in_ready_w[g]), 32'd0);
         check_eq($sformatf("busy_wait%0d", g), 32'(busy_w[g]), 32'd1);
      end
   endtask

   // Mock decoder: after a short latency, report the error magnitude of each
   // position in order; stop_at < N abandons the codeword part way.
   task automatic drain_cw(input bit gapped, input bit werr, input int stop_at);
      int p;
      dec_with_error = werr;
      repeat ($urandom_range(1, 10)) begin
         for (int g = 0; g < 2; g++)
            check_eq($sformatf("in_ready_lat%0d", g), 32'(in_ready_w[g]), 32'd0);
         dec_valid = 1'b0;
         step();
      end
      for (int q = 0; q < N; q++) push_exp({(q == N - 1), orig[q]});
      p = 0;
      while (p < stop_at) begin
         for (int g = 0; g < 2; g++)
            check_eq($sformatf("in_ready_drain%0d", g), 32'(in_ready_w[g]), 32'd0);
         if (gapped && ($urandom_range(0, 2) == 0)) begin
            dec_valid = 1'b0;
            dec_error = 8'($urandom);
         end else begin
            dec_valid = 1'b1;
            dec_error = rx[p] ^ orig[p];
            p++;
         end
         step();
      end
      if (stop_at < N) return;
      dec_valid = 1'b0;
      dec_error = 8'h00;
      step();
      dec_with_error = 1'b0;
      step();
      check_eq("out_pending0", 32'(g_dut[0].exp_q.size()), 32'd0);
      check_eq("out_pending1", 32'(g_dut[1].exp_q.size()), 32'd0);
      for (int g = 0; g < 2; g++) begin
         check_eq($sformatf("busy_done%0d", g), 32'(busy_w[g]), 32'd0);
         check_eq($sformatf("in_ready_done%0d", g), 32'(in_ready_w[g]), 32'd1);
      end
   endtask

   task automatic run_cw(input string tag, input int mode, input int nerr,
                         input bit gap_in, input bit gap_out);
      int ncorr;
      gen_cw(mode, nerr, ncorr);
      feed_cw(gap_in);
      drain_cw(gap_out, ncorr > 0, N);
      exp_cw++;
      if (ncorr > 0) exp_err++;
      exp_corr += ncorr;
      check_counts(tag);
   endtask

   initial begin
      int ncorr;
      int k;
      in_valid       = 1'b0;
      in_sym         = 8'h00;
      dec_valid      = 1'b0;
      dec_error      = 8'h00;
      dec_with_error = 1'b0;
      rst            = 1'b1;
      repeat (3) step();

      // Reset values.
      for (int g = 0; g < 2; g++) begin
         check_eq($sformatf("rst_in_ready%0d", g), 32'(in_ready_w[g]), 32'd0);
         check_eq($sformatf("rst_dec_en%0d", g), 32'(dec_enable_w[g]), 32'd0);
         check_eq($sformatf("rst_dec_x%0d", g), 32'(dec_x_w[g]), 32'd0);
         check_eq($sformatf("rst_out_valid%0d", g), 32'(out_valid_w[g]), 32'd0);
         check_eq($sformatf("rst_out_last%0d", g), 32'(out_last_w[g]), 32'd0);
         check_eq($sformatf("rst_out_sym%0d", g), 32'(out_sym_w[g]), 32'd0);
         check_eq($sformatf("rst_busy%0d", g), 32'(busy_w[g]), 32'd0);
         check_eq($sformatf("rst_state%0d", g), 32'(state_w[g]), 32'(IDLE));
         check_eq($sformatf("dec_k%0d", g), 32'(dec_k_w[g]), 32'(K));
      end
      check_counts("rst");
      rst = 1'b0;
      step();
      step();
      for (int g = 0; g < 2; g++)
         check_eq($sformatf("idle_in_ready%0d", g), 32'(in_ready_w[g]), 32'd1);

      // Clean codeword, then symbols 10/200 corrected, then gapped traffic.
      run_cw("clean", 0, 0, 1'b0, 1'b0);
      run_cw("corr", 1, 0, 1'b0, 1'b0);
      run_cw("gap", 2, int'($urandom_range(1, 6)), 1'b1, 1'b1);

      // Timeout: the decoder never answers.
      gen_cw(0, 0, ncorr);
      feed_cw(1'b0);
      k = 0;
      while (busy_w[0] && (k < TO + 20)) begin
         k++;
         step();
      end
      exp_to = 1'b1;
      check_eq("timeout_cycles", 32'(k), 32'(TO));
      for (int g = 0; g < 2; g++) begin
         check_eq($sformatf("tmo_state%0d", g), 32'(state_w[g]), 32'(IDLE));
         check_eq($sformatf("tmo_in_ready%0d", g), 32'(in_ready_w[g]), 32'd1);
         check_eq($sformatf("tmo_out_valid%0d", g), 32'(out_valid_w[g]), 32'd0);
      end
      check_counts("tmo");
      run_cw("after_tmo", 2, int'($urandom_range(0, 4)), 1'b0, 1'b1);

      // Reset while symbol 100 of the drain is due.
      gen_cw(2, 3, ncorr);
      feed_cw(1'b0);
      drain_cw(1'b0, ncorr > 0, 100);
      rst            = 1'b1;
      dec_valid      = 1'b0;
      dec_with_error = 1'b0;
      flush_exp();
      step();
      exp_cw   = 0;
      exp_err  = 0;
      exp_corr = 0;
      exp_to   = 1'b0;
      for (int g = 0; g < 2; g++) begin
         check_eq($sformatf("mid_rst_out_valid%0d", g), 32'(out_valid_w[g]), 32'd0);
         check_eq($sformatf("mid_rst_busy%0d", g), 32'(busy_w[g]), 32'd0);
      end
      check_counts("mid_rst");
      rst = 1'b0;
      step();
      step();
      for (int g = 0; g < 2; g++)
         check_eq($sformatf("mid_rst_in_ready%0d", g), 32'(in_ready_w[g]), 32'd1);
      run_cw("post_rst", 0, 0, 1'b0, 1'b0);

      // Enough further codewords to pin the 2-bit counters at all-ones.
      run_cw("sat_a", 2, int'($urandom_range(1, 5)), 1'b1, 1'b0);
      run_cw("sat_b", 1, 0, 1'b0, 1'b1);
      run_cw("sat_c", 2, int'($urandom_range(0, 8)), 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
